theta_bank_reader: RTL and testbench

- Angle-vector bank for the ICA flow. Stores the converged 6-angle CORDIC vector of each finished component.
- On request, streams the vectors of components 0..count-1 to the GSO rotation block, one vector per valid/ready beat.
- It is the read side of the normalisation-to-GSO theta path: the normaliser writes a slot when a component converges, and this block serves the stored slots back in index order.

---
 rtl/theta_bank_reader.sv | 168 ++++++++++++++++
 tb/tb_theta_bank_reader.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/theta_bank_reader.sv
// Angle-vector bank: stores one NUM_ANG-angle CORDIC vector per component and streams slots 0..cnt-1 out.
// Optional macro THETA_VALID_CHECK_EN adds per-slot valid bits, zeroing of unwritten beats and the sticky err flag.
module theta_bank_reader #(
    parameter int unsigned ANGLE_WIDTH = 16,
    parameter int unsigned NUM_ANG     = 6,
    parameter int unsigned NUM_COMP    = 7,
    parameter int unsigned IDX_W       = 3
) (
    input  logic                           clk,
    input  logic                           nreset,
    input  logic                           clr,
    input  logic                           wr_en,
    input  logic [IDX_W-1:0]               wr_comp,
    input  logic [NUM_ANG*ANGLE_WIDTH-1:0] wr_theta,
    output logic                           wr_drop,
    input  logic                           start,
    input  logic [IDX_W-1:0]               rd_count,
    output logic                           busy,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [NUM_ANG*ANGLE_WIDTH-1:0] out_theta,
    output logic [IDX_W-1:0]               out_comp,
    output logic                           out_last,
    output logic                           done,
    output logic                           err
);

    localparam int unsigned      THETA_W    = NUM_ANG * ANGLE_WIDTH;
    localparam logic [IDX_W-1:0] NUM_COMP_I = IDX_W'(NUM_COMP);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   cnt_q, cnt_d;
    logic               wr_drop_q, wr_drop_d;
    logic [THETA_W-1:0] slot_q [NUM_COMP];

    logic               busy_c;
    logic               clr_c;
    logic               wr_bad_c;
    logic               wr_ok_c;
    logic               ptr_ok_c;
    logic               last_c;
    logic [IDX_W-1:0]   start_cnt_c;
    logic [THETA_W-1:0] rd_theta_c;

    // Write qualification: clr only acts in IDLE and overrides a same-cycle write.
    always_comb begin
        busy_c      = (state_q != IDLE);
        clr_c       = clr && !busy_c;
        wr_bad_c    = wr_en && !clr_c &&
                      ((wr_comp >= NUM_COMP_I) || (busy_c && (wr_comp < cnt_q)));
        wr_ok_c     = wr_en && !clr_c && !wr_bad_c;
        ptr_ok_c    = (ptr_q < NUM_COMP_I);
        last_c      = (state_q == STREAM) && (ptr_q == (cnt_q - IDX_W'(1)));
        start_cnt_c = (rd_count > NUM_COMP_I) ? NUM_COMP_I : rd_count;
        rd_theta_c  = ptr_ok_c ? slot_q[ptr_q] : '0;
    end

    // Slot storage.
    always_ff @(posedge clk) begin
        if (nreset || clr_c) begin
            for (int i = 0; i < int'(NUM_COMP); i++) begin
                slot_q[i] <= '0;
            end
        end else if (wr_ok_c) begin
            slot_q[wr_comp] <= wr_theta;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        wr_drop_d = wr_bad_c;
        case (state_q)
            IDLE: begin
                if (start) begin
                    cnt_d   = start_cnt_c;
                    ptr_d   = '0;
                    state_d = (start_cnt_c == '0) ? DONE : STREAM;
                end
            end
            STREAM: begin
                if (out_ready) begin
                    ptr_d = ptr_q + IDX_W'(1);
                    if (last_c) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (nreset) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            cnt_q     <= '0;
            wr_drop_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            wr_drop_q <= wr_drop_d;
        end
    end

`ifdef THETA_VALID_CHECK_EN
    logic [NUM_COMP-1:0] vld_q;
    logic                err_q, err_d;
    logic                beat_vld_c;

    always_comb begin
        beat_vld_c = ptr_ok_c && vld_q[ptr_q];
        err_d      = err_q;
        if (clr_c) begin
            err_d = 1'b0;
        end else if ((state_q == STREAM) && !beat_vld_c) begin
            err_d = 1'b1;
        end
    end

    // Valid bits track which slots have been written since reset or clr.
    always_ff @(posedge clk) begin
        if (nreset || clr_c) begin
            vld_q <= '0;
        end else if (wr_ok_c) begin
            vld_q[wr_comp] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (nreset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign out_theta = ((state_q == STREAM) && beat_vld_c) ? rd_theta_c : '0;
    assign err       = err_q;
`else
    assign out_theta = (state_q == STREAM) ? rd_theta_c : '0;
    assign err       = 1'b0;
`endif

    assign busy      = busy_c;
    assign out_valid = (state_q == STREAM);
    assign out_comp  = (state_q == STREAM) ? ptr_q : '0;
    assign out_last  = last_c;
    assign done      = (state_q == DONE);
    assign wr_drop   = wr_drop_q;

endmodule

// File: tb/tb_theta_bank_reader.sv
// Randomized bench for theta_bank_reader against a queue-based transaction model of the bank and stream.
module tb_theta_bank_reader;

    localparam int TW = 96;
    localparam int NC = 7;

    logic          clk = 1'b0;
    logic          nreset, clr, wr_en, start, out_ready;
    logic [2:0]    wr_comp, rd_count;
    logic [TW-1:0] wr_theta;
    logic          wr_drop, busy, out_valid, out_last, done, err;
    logic [TW-1:0] out_theta;
    logic [2:0]    out_comp;

    theta_bank_reader dut (
        .clk(clk), .nreset(nreset), .clr(clr), .wr_en(wr_en), .wr_comp(wr_comp),
        .wr_theta(wr_theta), .wr_drop(wr_drop), .start(start), .rd_count(rd_count),
        .busy(busy), .out_valid(out_valid), .out_ready(out_ready), .out_theta(out_theta),
        .out_comp(out_comp), .out_last(out_last), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Reference model: bank contents plus the queue of slot indices still to be streamed.
    logic [TW-1:0] mslot [NC];
    bit            mvalid [NC];
    int            q[$];
    int            mode;      // 0 idle, 1 streaming, 2 done pulse
    int            mcnt;
    bit            mdrop, merr, mrst;

    task automatic check(input string tag, input logic [TW-1:0] got, input logic [TW-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [TW-1:0] exp_theta(input int idx);
`ifdef THETA_VALID_CHECK_EN
        return mvalid[idx] ? mslot[idx] : '0;
`else
        return mslot[idx];
`endif
    endfunction

    task automatic check_outputs();
        check("busy", TW'(busy), TW'(mode != 0));
        check("out_valid", TW'(out_valid), TW'(mode == 1));
        check("done", TW'(done), TW'(mode == 2));
        check("wr_drop", TW'(wr_drop), TW'(mdrop));
        check("err", TW'(err), TW'(merr));
        if (mode == 1) begin
            check("out_comp", TW'(out_comp), TW'(q[0]));
            check("out_theta", out_theta, exp_theta(q[0]));
            check("out_last", TW'(out_last), TW'(q.size() == 1));
        end
        if (mrst) begin
            check("rst_theta", out_theta, '0);
            check("rst_comp", TW'(out_comp), '0);
            check("rst_last", TW'(out_last), '0);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < NC; i++) begin
            mslot[i]  = '0;
            mvalid[i] = 1'b0;
        end
    endtask

    // Applies one clock edge's worth of spec behaviour using the inputs currently driven.
    task automatic model_step();
        bit was_busy;
        int c;
        if (nreset) begin
            model_clear();
            q.delete();
            mode = 0; mcnt = 0; mdrop = 0; merr = 0; mrst = 1;
            return;
        end
        mrst     = 0;
        was_busy = (mode != 0);
        mdrop    = 0;
`ifdef THETA_VALID_CHECK_EN
        if (mode == 1 && !mvalid[q[0]]) merr = 1;
`endif
        if (clr && !was_busy) begin
            model_clear();
            merr = 0;
        end else if (wr_en) begin
            if (int'(wr_comp) >= NC || (was_busy && int'(wr_comp) < mcnt)) mdrop = 1;
            else begin
                mslot[wr_comp]  = wr_theta;
                mvalid[wr_comp] = 1'b1;
            end
        end
        case (mode)
            0: if (start) begin
                c = (int'(rd_count) < NC) ? int'(rd_count) : NC;
                mcnt = c;
                q.delete();
                for (int i = 0; i < c; i++) q.push_back(i);
                mode = (c == 0) ? 2 : 1;
            end
            1: if (out_ready) begin
                void'(q.pop_front());
                if (q.size() == 0) mode = 2;
            end
            default: mode = 0;
        endcase
    endtask

    task automatic cyc();
        check_outputs();
        model_step();
        @(posedge clk);
        @(negedge clk);
        nreset = 0; clr = 0; wr_en = 0; start = 0;
    endtask

    task automatic do_write(input int slot, input logic [TW-1:0] v);
        wr_en = 1; wr_comp = 3'(slot); wr_theta = v;
    endtask

    task automatic do_start(input int n);
        start = 1; rd_count = 3'(n);
    endtask

    function automatic logic [TW-1:0] ramp(input logic [15:0] base);
        logic [TW-1:0] v;
        for (int j = 0; j < 6; j++) v[j*16 +: 16] = base + 16'(j + 1);
        return v;
    endfunction

    initial begin
        nreset = 1; clr = 0; wr_en = 0; start = 0; out_ready = 1;
        wr_comp = '0; rd_count = '0; wr_theta = '0;
        model_clear();
        q.delete();
        mode = 0; mcnt = 0; mdrop = 0; merr = 0; mrst = 1;
        @(posedge clk);
        @(negedge clk);
        nreset = 1; cyc();
        cyc();

        // Two-slot stream with ready held high.
        do_write(0, ramp(16'h0000)); cyc();
        do_write(1, ramp(16'h0010)); cyc();
        do_start(2); cyc();
        repeat (4) cyc();

        // Empty stream.
        do_start(0); cyc();
        repeat (3) cyc();

        // Three-slot stream with a two-cycle stall on beat 1, plus writes during the stream.
        do_write(2, ramp(16'h0020)); cyc();
        do_start(3); cyc();
        cyc();
        out_ready = 0; do_write(1, ramp(16'h0990)); cyc();
        do_write(4, ramp(16'h0040)); cyc();
        out_ready = 1; cyc();
        repeat (4) cyc();
        do_write(7, ramp(16'h0070)); cyc();
        cyc();
        do_start(5); cyc();
        repeat (7) cyc();

        // Reset at beat 1, then stream zeros.
        do_start(3); cyc();
        cyc();
        nreset = 1; cyc();
        cyc();
        do_start(2); cyc();
        repeat (4) cyc();

        // clr in idle, then stream an unwritten slot.
        do_write(0, ramp(16'h0100)); cyc();
        clr = 1; cyc();
        do_start(1); cyc();
        repeat (3) cyc();

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            nreset    = ($urandom_range(0, 199) == 0);
            clr       = ($urandom_range(0, 19) == 0);
            wr_en     = ($urandom_range(0, 2) == 0);
            wr_comp   = 3'($urandom_range(0, 7));
            wr_theta  = {$urandom, $urandom, $urandom};
            start     = ($urandom_range(0, 3) == 0);
            rd_count  = 3'($urandom_range(0, 7));
            out_ready = ($urandom_range(0, 9) < 7);
            cyc();
        end
        check_outputs();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
